aes_shift_rows_pipe: RTL and testbench
======================================

// Module: aes_shift_rows_pipe
// PURPOSE
//  Pipelined, mode-selectable (Inv)ShiftRows for the AES/Rijndael datapath. Each beat carries a state block
//  and an inv flag choosing forward ShiftRows or InvShiftRows. Supports Rijndael block widths via NB and an
//  elastic valid/ready pipeline of STAGES registers. It sits between (Inv)SubBytes and (Inv)MixColumns in
//  the shared encrypt/decrypt round.
// PARAMETERS
//  NB      4  state columns; legal 4, 6 or 8 (block width W = 32*NB bits: 128/192/256)
//  STAGES  1  register stages after the permutation; legal 1..4
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  synchronous active-low reset
//  flush      in   1  synchronous pipeline clear (drops all in-flight beats)
//  in_valid   in   1  input beat valid
//  in_ready   out  1  block can accept a beat this cycle
//  in_inv     in   1  0 = ShiftRows, 1 = InvShiftRows
//  in_state   in   W  state in column-major order: byte b = 4*c + r at bits [W-1-8b -: 8]
//  out_valid  out  1  output beat valid
//  out_ready  in   1  downstream accepts the beat
//  out_inv    out  1  in_inv of the beat being presented
//  out_state  out  W  permuted state, same byte order as in_state
//  beat_cnt   out  32 accepted-beat count (only with AES_SHIFTROWS_CNT_EN)
// BEHAVIOUR
//  - Row offsets s(r): NB=4 or 6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
//  - Forward: out[r][c] = in[r][(c + s(r)) mod NB]. Inverse: out[r][c] = in[r][(c - s(r)) mod NB].
//  - The permutation is applied combinationally at the input; the result and inv enter stage 0.
//  - Handshake: a transfer occurs when valid && ready on the same edge. A stage loads when it is empty or
//    its contents leave on that edge. in_ready = !flush && (stage0 empty || stage0 advancing).
//    in_ready never depends on in_valid. out_valid = last-stage valid.
//  - out_state and out_inv stay stable while out_valid && !out_ready.
//  - Latency: STAGES cycles from acceptance to out_valid with no stall. Throughput: 1 beat/clk.
//  - Bubbles collapse: an empty stage loads even when a later stage is stalled.
//  - Full pipe with out_ready=0: in_ready=0. When out_ready rises, in_ready rises in the same cycle.
//  - Simultaneous accept and emit on a full pipe: both occur, and occupancy is unchanged.
//  - flush: all stage valids clear on the next edge. No input is accepted in the flush cycle. Data
//    registers are not cleared.
//  - Reset (rst_n=0 at edge): all valids, data registers, out_inv and beat_cnt go to 0.
//    Reset in mid-stream discards all in-flight beats. in_ready=1 on the first cycle after reset is released.
//  - NB or STAGES outside the legal set: elaboration error ($error in generate).
// CONFIGURATION
//  AES_SHIFTROWS_CNT_EN defined:
//  - beat_cnt increments by 1 per accepted input beat (in_valid && in_ready) and saturates at 32'hFFFF_FFFF.
//  - beat_cnt clears on reset but not on flush.
//  AES_SHIFTROWS_CNT_EN undefined: the beat_cnt port and its counter logic are absent.
// STRUCTURE
//  - Shared package aes_pkg: AES_ROWS=4, typedef byte_t, function shift_off(nb,row), function
//    byte_idx(row,col), and the legal-NB constant list.
//  - Sub-module aes_pipe_stage: one elastic register stage (valid, inv, W-bit data, ready-through).
//    The top instantiates STAGES of them in a generate loop, after the combinational permutation.
// TESTING
//  1 NB=4, inv=0, in=d42711aee0bf98f1b8b45de51e415230 (FIPS-197 round 1)
//    -> out=d4bf5d30e0b452aeb84111f11e2798e5 after STAGES clocks.
//  2 NB=4, inv=1, in=d4bf5d30e0b452aeb84111f11e2798e5
//    -> out=d42711aee0bf98f1b8b45de51e415230. Random states: inv(fwd(x))==x, 1000 beats.
//  3 NB=8, inv=0, bytes 00..1f in order
//    -> row1 rotated by 1 column, row2 by 3, row3 by 4. Example: out byte (r3,c0)=in byte (r3,c4)=8'h13.
//  4 STAGES=3, 20 back-to-back beats, out_ready=0 for cycles 5..9
//    -> no loss or duplication, order kept, in_ready=0 only once 3 beats are held, 1 beat/clk after release.
//  5 Pipe holding 2 beats, flush=1 for 1 cycle with in_valid=1
//    -> out_valid=0 next cycle, flush-cycle beat not accepted, beat_cnt unchanged by flush.
//  6 rst_n=0 for 1 cycle mid-stream -> all outputs 0 next cycle. With CNT_EN, beat_cnt preloaded near max
//    via force -> saturates at FFFF_FFFF.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: state geometry, legal Rijndael block widths and ShiftRows row offsets.
package aes_pkg;

    localparam int AES_ROWS = 4;

    typedef logic [7:0] byte_t;

    localparam int LEGAL_NB [3] = '{4, 6, 8};

    function automatic bit nb_legal(input int nb);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (LEGAL_NB[i] == nb) ok = 1'b1;
        end
        return ok;
    endfunction

    // Rijndael with 256-bit blocks shifts rows 2 and 3 one column further than the narrower widths.
    function automatic int shift_off(input int nb, input int row);
        return (nb == 8 && row >= 2) ? row + 1 : row;
    endfunction

    function automatic int byte_idx(input int row, input int col);
        return AES_ROWS * col + row;
    endfunction

endpackage

// File: rtl/aes_pipe_stage.sv
// One elastic valid/ready register stage carrying the inv flag and a W-bit state.
module aes_pipe_stage #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic         up_inv,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic         dn_inv,
    output logic [W-1:0] dn_data
);

    // Loads when empty or when the held beat leaves on this edge; this is what collapses bubbles.
    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_inv   <= 1'b0;
            dn_data  <= '0;
        end else begin
            if (flush) begin
                dn_valid <= 1'b0;
            end else if (up_ready) begin
                dn_valid <= up_valid;
            end
            if (up_ready && up_valid) begin
                dn_inv  <= up_inv;
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Pipelined forward/inverse ShiftRows for NB = 4/6/8 column Rijndael states, STAGES elastic registers deep.
// Define AES_SHIFTROWS_CNT_EN to add the saturating accepted-beat counter on port beat_cnt.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [32*NB-1:0]  in_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_inv,
    output logic [32*NB-1:0]  out_state
`ifdef AES_SHIFTROWS_CNT_EN
    ,
    output logic [31:0]       beat_cnt
`endif
);

    localparam int W = 32 * NB;

    generate
        if (!nb_legal(NB)) begin : g_bad_nb
            $error("aes_shift_rows_pipe: NB=%0d is not 4, 6 or 8", NB);
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("aes_shift_rows_pipe: STAGES=%0d is outside 1..4", STAGES);
        end
    endgenerate

    byte_t        grid [AES_ROWS][NB];
    logic [W-1:0] perm_state;

    always_comb begin
        int src;
        src        = 0;
        perm_state = '0;
        for (int r = 0; r < AES_ROWS; r++) begin
            for (int c = 0; c < NB; c++) begin
                grid[r][c] = in_state[W-1-8*byte_idx(r, c) -: 8];
            end
        end
        for (int r = 0; r < AES_ROWS; r++) begin
            for (int c = 0; c < NB; c++) begin
                src = in_inv ? (c + NB - shift_off(NB, r)) % NB : (c + shift_off(NB, r)) % NB;
                perm_state[W-1-8*byte_idx(r, c) -: 8] = grid[r][src];
            end
        end
    end

    // Stage boundary: permuted state enters the register chain.
    logic         vld_p [STAGES+1];
    logic         rdy_p [STAGES+1];
    logic         inv_p [STAGES+1];
    logic [W-1:0] dat_p [STAGES+1];

    assign vld_p[0]      = in_valid && !flush;
    assign inv_p[0]      = in_inv;
    assign dat_p[0]      = perm_state;
    assign rdy_p[STAGES] = out_ready;
    assign in_ready      = !flush && rdy_p[0];

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            aes_pipe_stage #(
                .W(W)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (flush),
                .up_valid (vld_p[i]),
                .up_ready (rdy_p[i]),
                .up_inv   (inv_p[i]),
                .up_data  (dat_p[i]),
                .dn_valid (vld_p[i+1]),
                .dn_ready (rdy_p[i+1]),
                .dn_inv   (inv_p[i+1]),
                .dn_data  (dat_p[i+1])
            );
        end
    endgenerate

    assign out_valid = vld_p[STAGES];
    assign out_inv   = inv_p[STAGES];
    assign out_state = dat_p[STAGES];

`ifdef AES_SHIFTROWS_CNT_EN
    // Counts survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (in_valid && in_ready && beat_cnt != 32'hFFFF_FFFF) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed and random bench for aes_shift_rows_pipe: NB=4/STAGES=3 instance checked by a queue model, NB=8 instance by vectors.
module tb_aes_shift_rows_pipe;

    localparam int ST_A = 3;
    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_inv = 1'b0;
    logic [127:0] in_state = '0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid, out_inv;
    logic [127:0] out_state;

    logic         b_in_valid = 1'b0;
    logic         b_in_inv = 1'b0;
    logic [255:0] b_in_state = '0;
    logic         b_in_ready, b_out_valid, b_out_inv;
    logic [255:0] b_out_state;

`ifdef AES_SHIFTROWS_CNT_EN
    logic [31:0]  beat_cnt, b_beat_cnt;
`endif

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;
    int emitted = 0;
    logic [31:0] exp_cnt = '0;

    typedef struct {
        logic [127:0] d;
        logic         inv;
        int           pos;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    aes_shift_rows_pipe #(.NB(4), .STAGES(ST_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .out_state(out_state)
`ifdef AES_SHIFTROWS_CNT_EN
        , .beat_cnt(beat_cnt)
`endif
    );

    aes_shift_rows_pipe #(.NB(8), .STAGES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_state(b_in_state),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_inv(b_out_inv), .out_state(b_out_state)
`ifdef AES_SHIFTROWS_CNT_EN
        , .beat_cnt(b_beat_cnt)
`endif
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference permutation from the row/column definition; the block lives in the low 32*nb bits.
    function automatic logic [255:0] ref_perm(input logic [255:0] x, input int nb, input bit inv);
        logic [7:0]   m [4][8];
        logic [255:0] y;
        int w, s, src;
        w = 32 * nb;
        y = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = x[w-1-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++) begin
            s = (nb == 8 && r > 1) ? r + 1 : r;
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - s + nb) % nb : (c + s) % nb;
                y[w-1-8*(4*c+r) -: 8] = m[r][src];
            end
        end
        return y;
    endfunction

    // Model of the elastic pipe: each in-flight beat has a stage position and advances when the slot ahead frees.
    always @(posedge clk) begin : model
        bit           acc;
        int           lim;
        logic [255:0] tmp;
        ent_t         e;
        if (!rst_n) begin
            q.delete();
            exp_cnt = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < ST_A || out_ready);
            if (q.size() > 0 && q[0].pos == ST_A - 1 && out_ready) begin
                void'(q.pop_front());
                emitted++;
            end
            for (int i = 0; i < q.size(); i++) begin
                lim = (i == 0) ? ST_A : q[i-1].pos;
                if (q[i].pos + 1 < lim) q[i].pos = q[i].pos + 1;
            end
            if (acc) begin
                tmp   = ref_perm({128'b0, in_state}, 4, in_inv);
                e.d   = tmp[127:0];
                e.inv = in_inv;
                e.pos = 0;
                q.push_back(e);
                if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit ov;
        if (chk_en) begin
            chk("in_ready", {255'b0, in_ready}, {255'b0, !flush && (q.size() < ST_A || out_ready)});
            ov = q.size() > 0 && q[0].pos == ST_A - 1;
            chk("out_valid", {255'b0, out_valid}, {255'b0, ov});
            if (ov) begin
                chk("out_state", {128'b0, out_state}, {128'b0, q[0].d});
                chk("out_inv", {255'b0, out_inv}, {255'b0, q[0].inv});
            end
`ifdef AES_SHIFTROWS_CNT_EN
            chk("beat_cnt", {224'b0, beat_cnt}, {224'b0, exp_cnt});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] s, input logic iv);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_state = s;
        in_inv   = iv;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            nvec++;
            nerr++;
            $display("FAIL send: beat %h not accepted within 50 cycles", s);
        end
    endtask

    task automatic latency_check(input string name, input logic [127:0] s, input logic iv, input logic [127:0] exp);
        int lat;
        in_valid = 1'b1;
        in_state = s;
        in_inv   = iv;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, lat, ST_A);
        chk({name, "_state"}, {128'b0, out_state}, {128'b0, exp});
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [255:0] nb8_in, nb8_out;
        logic [31:0]  cnt_save;
        int sent, cyc, e0;

        tick();
        chk_en = 1'b1;
        chk("rst_out_valid", {255'b0, out_valid}, 256'd0);
        chk("rst_out_state", {128'b0, out_state}, 256'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {255'b0, in_ready}, 256'd1);
        tick();

        chk("model_fips", ref_perm({128'b0, FIPS_IN}, 4, 1'b0), {128'b0, FIPS_OUT});
        latency_check("t1_fwd", FIPS_IN, 1'b0, FIPS_OUT);
        latency_check("t2_inv", FIPS_OUT, 1'b1, FIPS_IN);

        // NB=8: byte b holds value b.
        for (int b = 0; b < 32; b++) nb8_in[255-8*b -: 8] = 8'(b);
        b_in_state = nb8_in;
        b_in_inv   = 1'b0;
        b_in_valid = 1'b1;
        #1;
        chk("t3_b_in_ready", {255'b0, b_in_ready}, 256'd1);
        tick();
        b_in_valid = 1'b0;
        nb8_out = b_out_state;
        chk("t3_b_out_valid", {255'b0, b_out_valid}, 256'd1);
        chk("t3_b_r3c0", {248'b0, nb8_out[255-8*3 -: 8]}, 256'h13);
        chk("t3_b_r1c7", {248'b0, nb8_out[255-8*29 -: 8]}, 256'h01);
        chk("t3_b_r2c0", {248'b0, nb8_out[255-8*2 -: 8]}, 256'h0e);
        chk("t3_b_full", nb8_out, ref_perm(nb8_in, 8, 1'b0));
        b_in_state = nb8_out;
        b_in_inv   = 1'b1;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        chk("t3_b_roundtrip", b_out_state, nb8_in);
        chk("t3_b_out_inv", {255'b0, b_out_inv}, 256'd1);

        // 20 back-to-back beats with a downstream stall on cycles 5..9.
        sent = 0;
        cyc  = 0;
        e0   = emitted;
        while ((sent < 20 || emitted - e0 < 20) && cyc < 200) begin
            out_ready = !(cyc >= 5 && cyc <= 9);
            in_valid  = (sent < 20);
            in_state  = {4{32'h0101_0101 * (sent + 1)}} ^ 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
            in_inv    = sent[0];
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4_emitted", emitted - e0, 20);
        tick();

        // Flush with two beats held and a beat offered in the flush cycle.
        out_ready = 1'b0;
        send(128'h0102030405060708090a0b0c0d0e0f10, 1'b0);
        send(128'h1112131415161718191a1b1c1d1e1f20, 1'b1);
        cnt_save = exp_cnt;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_state = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        #1;
        chk("t5_flush_in_ready", {255'b0, in_ready}, 256'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t5_out_valid", {255'b0, out_valid}, 256'd0);
`ifdef AES_SHIFTROWS_CNT_EN
        chk("t5_beat_cnt", {224'b0, beat_cnt}, {224'b0, cnt_save});
`endif
        out_ready = 1'b1;
        tick();

        // Reset in mid-stream.
        send(128'h2122232425262728292a2b2c2d2e2f30, 1'b1);
        send(128'h3132333435363738393a3b3c3d3e3f40, 1'b1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_state = 128'h4142434445464748494a4b4c4d4e4f50;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("t6_out_valid", {255'b0, out_valid}, 256'd0);
        chk("t6_out_state", {128'b0, out_state}, 256'd0);
        chk("t6_out_inv", {255'b0, out_inv}, 256'd0);
        chk("t6_in_ready", {255'b0, in_ready}, 256'd1);
`ifdef AES_SHIFTROWS_CNT_EN
        chk("t6_beat_cnt", {224'b0, beat_cnt}, 256'd0);
        tick();
        force dut_a.beat_cnt = 32'hFFFF_FFFD;
        exp_cnt = 32'hFFFF_FFFD;
        #1;
        release dut_a.beat_cnt;
        for (int i = 0; i < 4; i++) send(128'(i) << 64, 1'b0);
        chk("t6_cnt_sat", {224'b0, beat_cnt}, 256'h0FFFF_FFFF);
`endif
        tick();

        // Random traffic; every output beat is checked by the model.
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inv    = 1'($urandom_range(0, 1));
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t2_random_sent", sent, 1000);
        for (int i = 0; i < 2 * ST_A; i++) tick();
        chk("t2_drained", {255'b0, out_valid}, 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
